// File: rtl/exe_alu_stage_pkg.sv
// Shared widths, buffer depth and execute-stage structs for the ALU path.
// alu_operand() is the operand-select mux used by the ALU functional unit.
package cpu_params_pkg;
    localparam int RSZ               = 32;
    localparam int PC_SZ             = 32;
    localparam int EXE_ALU_BUF_DEPTH = 2;
endpackage

package cpu_structs_pkg;
    import cpu_params_pkg::*;

    typedef enum logic [1:0] {AM_RS1, AM_RS2, AM_IMM, AM_PC} ALU_SEL_TYPE;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
    } ALU_OP_TYPE;

    typedef struct packed {
        logic [RSZ-1:0]   Rs1_data;
        logic [RSZ-1:0]   Rs2_data;
        logic [RSZ-1:0]   imm;
        logic [PC_SZ-1:0] pc;
        ALU_SEL_TYPE      sel_x;
        ALU_SEL_TYPE      sel_y;
        ALU_OP_TYPE       op;
        logic [4:0]       Rd_addr;
        logic             rd_wr;
    } EXE_ALU_IN_TYPE;

    typedef struct packed {
        logic [RSZ-1:0]   Rd_data;
        logic [4:0]       Rd_addr;
        logic             rd_wr;
        logic [PC_SZ-1:0] pc;
    } EXE_ALU_OUT_TYPE;

    function automatic logic [RSZ-1:0] alu_operand(ALU_SEL_TYPE sel, logic [RSZ-1:0] rs1,
                                                   logic [RSZ-1:0] rs2, logic [RSZ-1:0] imm,
                                                   logic [PC_SZ-1:0] pc);
        case (sel)
            AM_RS1:  return rs1;
            AM_RS2:  return rs2;
            AM_IMM:  return imm;
            default: return RSZ'(pc);
        endcase
    endfunction
endpackage

// File: rtl/exe_alu_stage_if.sv
// Operand/select bus between the execute stage (master) and the ALU unit (slave).
interface AFU_intf;
    import cpu_params_pkg::*;
    import cpu_structs_pkg::*;

    logic [RSZ-1:0]   Rs1_data;
    logic [RSZ-1:0]   Rs2_data;
    logic [RSZ-1:0]   imm;
    logic [PC_SZ-1:0] pc;
    ALU_SEL_TYPE      sel_x;
    ALU_SEL_TYPE      sel_y;
    ALU_OP_TYPE       op;
    logic [RSZ-1:0]   Rd_data;

    modport master (output Rs1_data, Rs2_data, imm, pc, sel_x, sel_y, op, input Rd_data);
    modport slave  (input Rs1_data, Rs2_data, imm, pc, sel_x, sel_y, op, output Rd_data);
endinterface

// File: rtl/alu_fu.sv
// Combinational ALU functional unit; result settles within the cycle it is driven.
module alu_fu
    import cpu_params_pkg::*;
    import cpu_structs_pkg::*;
(
    AFU_intf.slave afu
);
    logic [RSZ-1:0] x, y;

    assign x = alu_operand(afu.sel_x, afu.Rs1_data, afu.Rs2_data, afu.imm, afu.pc);
    assign y = alu_operand(afu.sel_y, afu.Rs1_data, afu.Rs2_data, afu.imm, afu.pc);

    always_comb begin
        case (afu.op)
            ALU_ADD:  afu.Rd_data = x + y;
            ALU_SUB:  afu.Rd_data = x - y;
            ALU_AND:  afu.Rd_data = x & y;
            ALU_OR:   afu.Rd_data = x | y;
            ALU_XOR:  afu.Rd_data = x ^ y;
            ALU_SLL:  afu.Rd_data = x << y[4:0];
            ALU_SRL:  afu.Rd_data = x >> y[4:0];
            ALU_SRA:  afu.Rd_data = $signed(x) >>> y[4:0];
            ALU_SLT:  afu.Rd_data = RSZ'($signed(x) < $signed(y));
            ALU_SLTU: afu.Rd_data = RSZ'(x < y);
            default:  afu.Rd_data = '0;
        endcase
    end
endmodule

// File: rtl/exe_alu_stage_skid_buf.sv
// Generic 2-entry in-order buffer with occupancy count; flush beats push/pop.
// Caller guarantees no push when full and no pop when empty.
module exe_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic [1:0]   count
);
    logic [W-1:0] mem [2];
    logic         wr_ptr, rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (flush) begin
            count  <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head = mem[rd_ptr];
endmodule

// File: rtl/exe_alu_stage.sv
// Execute-stage ALU wrapper: drives alu_fu over AFU_intf, buffers results for MEM.
// Define EXE_ALU_FWD_EN to build the operand-forwarding outputs; otherwise they read 0.
module exe_alu_stage
    import cpu_params_pkg::*;
    import cpu_structs_pkg::*;
(
    input  logic            clk_in,
    input  logic            reset_in_n,
    input  logic            dec_valid_in,
    output logic            dec_rdy_out,
    input  EXE_ALU_IN_TYPE  dec_data_in,
    AFU_intf.master         afu_bus,
    output logic            exe_valid_out,
    input  logic            mem_rdy_in,
    output EXE_ALU_OUT_TYPE exe_data_out,
    input  logic            flush_in,
    output logic            fwd_valid_out,
    output logic [4:0]      fwd_Rd_addr_out,
    output logic [RSZ-1:0]  fwd_Rd_data_out,
    output logic [31:0]     alu_retired_out
);
    logic [1:0]      count;
    logic            push, pop;
    logic [31:0]     retired_q;
    EXE_ALU_OUT_TYPE entry_in;

    // Ready depends only on registered occupancy, never on mem_rdy_in.
    assign dec_rdy_out   = (count != 2'(EXE_ALU_BUF_DEPTH));
    assign exe_valid_out = (count != 2'd0);
    assign push          = dec_valid_in & dec_rdy_out & ~flush_in;
    assign pop           = exe_valid_out & mem_rdy_in & ~flush_in;

    assign afu_bus.Rs1_data = dec_data_in.Rs1_data;
    assign afu_bus.Rs2_data = dec_data_in.Rs2_data;
    assign afu_bus.imm      = dec_data_in.imm;
    assign afu_bus.pc       = dec_data_in.pc;
    assign afu_bus.sel_x    = dec_data_in.sel_x;
    assign afu_bus.sel_y    = dec_data_in.sel_y;
    assign afu_bus.op       = dec_data_in.op;

    always_comb begin
        entry_in         = '0;
        entry_in.Rd_data = afu_bus.Rd_data;
        entry_in.Rd_addr = dec_data_in.Rd_addr;
        entry_in.rd_wr   = dec_data_in.rd_wr;
        entry_in.pc      = dec_data_in.pc;
    end

    exe_skid_buf #(.W($bits(EXE_ALU_OUT_TYPE))) u_buf (
        .clk   (clk_in),
        .rst_n (reset_in_n),
        .push  (push),
        .pop   (pop),
        .flush (flush_in),
        .din   (entry_in),
        .head  (exe_data_out),
        .count (count)
    );

    always_ff @(posedge clk_in or negedge reset_in_n) begin
        if (!reset_in_n)  retired_q <= '0;
        else if (pop)     retired_q <= retired_q + 32'd1;
    end
    assign alu_retired_out = retired_q;

`ifdef EXE_ALU_FWD_EN
    // Tracks the newest buffered entry: a push replaces it, draining the last entry drops it.
    always_ff @(posedge clk_in or negedge reset_in_n) begin
        if (!reset_in_n) begin
            fwd_valid_out   <= 1'b0;
            fwd_Rd_addr_out <= '0;
            fwd_Rd_data_out <= '0;
        end else if (flush_in) begin
            fwd_valid_out   <= 1'b0;
        end else if (push) begin
            fwd_valid_out   <= entry_in.rd_wr & (entry_in.Rd_addr != 5'd0);
            fwd_Rd_addr_out <= entry_in.Rd_addr;
            fwd_Rd_data_out <= entry_in.Rd_data;
        end else if (pop && count == 2'd1) begin
            fwd_valid_out   <= 1'b0;
        end
    end
`else
    assign fwd_valid_out   = 1'b0;
    assign fwd_Rd_addr_out = '0;
    assign fwd_Rd_data_out = '0;
`endif
endmodule
